apu_stereo_mixer: RTL
=====================

Name: apu_stereo_mixer

Overview:
- Parametrised, time-multiplexed stereo mixer for the sound subsystem. Replaces the fixed three-channel level hand-off into the AC97 codec with a generic NUM_CH mixer.
- On each codec sample request it snapshots every channel level and applies per-channel SO1/SO2 panning enables, per-side master volume and the global sound enable.
- Produces signed, DC-centred left/right PCM samples with a one-cycle valid pulse.

Parameters:
- NUM_CH, 4: number of channel inputs, at least 1.
- LEVEL_W, 4: width of each unsigned channel level.
- VOL_W, 3: width of each side's master volume.
- OUT_W, 16: signed output sample width. Must satisfy OUT_W >= ACC_W, where ACC_W = LEVEL_W+1+clog2(NUM_CH)+VOL_W.

Ports:
- ac97_bitclk  in  1: sole clock; all logic on the rising edge.
- reset_n  in  1: synchronous, active-low reset.
- sample_req  in  1: one-cycle request pulse from the codec frame strobe.
- ch_levels  in  NUM_CH*LEVEL_W: channel i occupies bits [i*LEVEL_W +: LEVEL_W].
- so1_ch_enable  in  NUM_CH: bit i routes channel i to left (SO1).
- so2_ch_enable  in  NUM_CH: bit i routes channel i to right (SO2).
- so1_output_level  in  VOL_W: left master volume, gain = value+1.
- so2_output_level  in  VOL_W: right master volume, gain = value+1.
- master_sound_enable  in  1: 0 forces silent (zero) output.
- left_sample  out  OUT_W: signed left PCM sample.
- right_sample  out  OUT_W: signed right PCM sample.
- sample_valid  out  1: one-cycle pulse when left_sample/right_sample update.
- busy  out  1: high while a mix is in progress.
- overrun  out  1: sticky flag; set when sample_req arrives while busy.

Behaviour:
- Reset (reset_n=0 at a clock edge): state IDLE. left_sample=0, right_sample=0, sample_valid=0, busy=0, overrun=0. Accumulators and channel index cleared. Applies mid-operation too; the in-flight mix is discarded and no valid pulse is produced.
- FSM states: IDLE, ACCUM, SCALE.
- IDLE + sample_req=1 (cycle 0):
  - snapshot ch_levels, both enable vectors, both volumes and master_sound_enable;
  - clear both accumulators; index=0; go to ACCUM.
  - Inputs changed after cycle 0 do not affect this sample.
- ACCUM, cycles 1..NUM_CH: one channel per cycle.
  - signed value s = 2*level - (2^LEVEL_W - 1), an odd value in ±(2^LEVEL_W - 1); for LEVEL_W=4: level 0 -> -15, 7 -> -1, 8 -> +1, 15 -> +15.
  - add s to the left accumulator if so1 bit[index] is set; add s to the right accumulator if so2 bit[index] is set.
  - index increments; after index NUM_CH-1, go to SCALE.
- SCALE, cycle NUM_CH+1:
  - left = accL*(so1_output_level+1); right = accR*(so2_output_level+1).
  - compute in ACC_W-bit signed arithmetic; this never overflows.
  - if the snapshotted master_sound_enable is 0, both results are 0.
  - result is sign-extended and left-shifted by OUT_W-ACC_W into the output registers; go to IDLE.
- Cycle NUM_CH+2: sample_valid=1 for exactly one cycle with the new outputs visible. Outputs then hold until the next update.
- busy=1 exactly in ACCUM and SCALE.
- Latency: request-to-valid is fixed at NUM_CH+2 cycles.
- sample_req while busy: ignored; no restart; overrun set to 1 and held until reset. The in-progress mix completes normally.
- sample_req in the same cycle as sample_valid: state is IDLE, so it is accepted normally.
- Both enable bits clear for all channels: the corresponding side outputs 0.
- Defaults (NUM_CH=4, LEVEL_W=4, VOL_W=3, OUT_W=16): ACC_W=10, shift=6, full scale ±30720.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with sample_req toggling -> all outputs 0; no sample_valid.
- Full positive: all levels 15, so1=so2=4'hF, volumes 7, master 1, pulse req at cycle 0 -> busy=1 for cycles 1–5; sample_valid only at cycle 6; left=right=30720. Repeat with all levels 0 -> -30720.
- Panning and volume: ch0 level 8, others 7, so1=4'b0001, so2=4'b1110, so1 vol 0, so2 vol 2 -> left=+64; right=(-3*3)<<6=-576.
- Master disable and snapshot: same stimulus with master_sound_enable=0 -> both 0, valid still at cycle 6. Separately, change all levels at cycle 2 -> output reflects the cycle-0 values.
- Overrun: req at cycle 0 and again at cycle 3 -> single valid at cycle 6; overrun=1 from cycle 4 onward. A req at cycle 6 is accepted -> valid at cycle 12.
- Mid-operation reset: reset_n=0 at cycle 3 -> no valid pulse; outputs 0. A later req produces a correct sample after NUM_CH+2 cycles.

Source files
------------

// File: rtl/apu_stereo_mixer_if.sv
// Sample-request / mix-result bundle between the codec frame logic and the stereo mixer.
// The master drives requests and channel controls; the slave (mixer) returns PCM samples.
interface apu_stereo_mixer_if #(
  parameter int NUM_CH  = 4,
  parameter int LEVEL_W = 4,
  parameter int VOL_W   = 3,
  parameter int OUT_W   = 16
);
  logic                        sample_req;
  logic [NUM_CH*LEVEL_W-1:0]   ch_levels;
  logic [NUM_CH-1:0]           so1_ch_enable;
  logic [NUM_CH-1:0]           so2_ch_enable;
  logic [VOL_W-1:0]            so1_output_level;
  logic [VOL_W-1:0]            so2_output_level;
  logic                        master_sound_enable;
  logic [OUT_W-1:0]            left_sample;
  logic [OUT_W-1:0]            right_sample;
  logic                        sample_valid;
  logic                        busy;
  logic                        overrun;

  modport master (
    output sample_req, ch_levels, so1_ch_enable, so2_ch_enable,
           so1_output_level, so2_output_level, master_sound_enable,
    input  left_sample, right_sample, sample_valid, busy, overrun
  );

  modport slave (
    input  sample_req, ch_levels, so1_ch_enable, so2_ch_enable,
           so1_output_level, so2_output_level, master_sound_enable,
    output left_sample, right_sample, sample_valid, busy, overrun
  );
endinterface

// File: rtl/apu_stereo_mixer.sv
// Time-multiplexed NUM_CH stereo mixer: snapshot on request, accumulate one channel
// per cycle, then scale by per-side volume into signed DC-centred PCM samples.
module apu_stereo_mixer #(
  parameter int NUM_CH  = 4,
  parameter int LEVEL_W = 4,
  parameter int VOL_W   = 3,
  parameter int OUT_W   = 16
) (
  input  logic               ac97_bitclk,
  input  logic               reset_n,
  apu_stereo_mixer_if.slave  bus
);
  localparam int ACC_W = LEVEL_W + 1 + $clog2(NUM_CH) + VOL_W;
  localparam int SHIFT = OUT_W - ACC_W;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic signed [ACC_W-1:0] LVL_OFS = ACC_W'((1 << LEVEL_W) - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE} state_e;

  state_e                     state_q, state_d;
  logic [NUM_CH*LEVEL_W-1:0]  lvl_q, lvl_d;
  logic [NUM_CH-1:0]          so1_q, so1_d, so2_q, so2_d;
  logic [VOL_W-1:0]           vol1_q, vol1_d, vol2_q, vol2_d;
  logic                       en_q, en_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic signed [ACC_W-1:0]    acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [OUT_W-1:0]    left_q, left_d, right_q, right_d;
  logic                       valid_q, valid_d;
  logic                       overrun_q, overrun_d;

  logic [LEVEL_W-1:0]         cur_lvl;
  logic signed [ACC_W-1:0]    cur_s, gain_l, gain_r, prod_l, prod_r;

  // NOTE: every combinational output is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    so1_d     = so1_q;
    so2_d     = so2_q;
    vol1_d    = vol1_q;
    vol2_d    = vol2_q;
    en_d      = en_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (bus.sample_req & (state_q != IDLE));

    // Map unsigned level onto odd values symmetric about zero so silence has no DC offset.
    cur_lvl = lvl_q[idx_q*LEVEL_W +: LEVEL_W];
    cur_s   = $signed(ACC_W'({cur_lvl, 1'b0})) - LVL_OFS;
    gain_l  = $signed(ACC_W'(vol1_q) + ACC_W'(1));
    gain_r  = $signed(ACC_W'(vol2_q) + ACC_W'(1));
    prod_l  = acc_l_q * gain_l;
    prod_r  = acc_r_q * gain_r;

    case (state_q)
      IDLE: begin
        if (bus.sample_req) begin
          lvl_d   = bus.ch_levels;
          so1_d   = bus.so1_ch_enable;
          so2_d   = bus.so2_ch_enable;
          vol1_d  = bus.so1_output_level;
          vol2_d  = bus.so2_output_level;
          en_d    = bus.master_sound_enable;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (so1_q[idx_q]) acc_l_d = acc_l_q + cur_s;
        if (so2_q[idx_q]) acc_r_d = acc_r_q + cur_s;
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          state_d = SCALE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SCALE: begin
        // Width sizing guarantees the product fits ACC_W; widen then justify to full scale.
        left_d  = en_q ? (OUT_W'(prod_l) <<< SHIFT) : '0;
        right_d = en_q ? (OUT_W'(prod_r) <<< SHIFT) : '0;
        valid_d = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge ac97_bitclk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      lvl_q     <= '0;
      so1_q     <= '0;
      so2_q     <= '0;
      vol1_q    <= '0;
      vol2_q    <= '0;
      en_q      <= 1'b0;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lvl_q     <= lvl_d;
      so1_q     <= so1_d;
      so2_q     <= so2_d;
      vol1_q    <= vol1_d;
      vol2_q    <= vol2_d;
      en_q      <= en_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.left_sample  = left_q;
  assign bus.right_sample = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.overrun      = overrun_q;
endmodule
